// File: rtl/sync_fifo_lvl_if.sv
// Handshake, data and status bundle for sync_fifo_lvl.
// master: the producer/consumer side driving requests; slave: the FIFO itself.
interface sync_fifo_lvl_if #(
  parameter int DATA_W  = 32,
  parameter int DEPTH_W = 3
);
  logic              wr_en;
  logic [DATA_W-1:0] wr_dat;
  logic              rd_en;
  logic [DATA_W-1:0] rd_dat;
  logic              rd_dat_vld;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [DEPTH_W:0]  level;
  logic              err_clr;
  logic              ovf_err;
  logic              udf_err;

  modport master (
    output wr_en, wr_dat, rd_en, err_clr,
    input  rd_dat, rd_dat_vld, full, empty, almost_full, almost_empty,
           level, ovf_err, udf_err
  );

  modport slave (
    input  wr_en, wr_dat, rd_en, err_clr,
    output rd_dat, rd_dat_vld, full, empty, almost_full, almost_empty,
           level, ovf_err, udf_err
  );
endinterface

// File: rtl/sync_fifo_lvl.sv
// Synchronous FIFO with occupancy level, almost-full/empty thresholds and
// sticky overflow/underflow flags.
// Build option: define SYNC_FIFO_LVL_FWFT_EN for first-word-fall-through
// read data; otherwise reads have one cycle of latency through a register.
module sync_fifo_lvl #(
  parameter int DEPTH   = 8,
  parameter int DEPTH_W = 3,
  parameter int DATA_W  = 32,
  parameter int AF_LVL  = DEPTH - 2,
  parameter int AE_LVL  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  sync_fifo_lvl_if.slave  bus
);

  localparam int PTR_W = DEPTH_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [PTR_W-1:0]   level;
  logic [DEPTH_W-1:0] wr_idx;
  logic [DEPTH_W-1:0] rd_idx;
  logic               full;
  logic               empty;
  logic               wr_acc;
  logic               rd_acc;
  logic               ovf_err_reg;
  logic               ovf_err_next;
  logic               udf_err_reg;
  logic               udf_err_next;

  // The pointer MSB is a wrap flag, so the plain modulo difference gives 0..DEPTH.
  assign level  = wr_ptr_reg - rd_ptr_reg;
  assign wr_idx = wr_ptr_reg[DEPTH_W-1:0];
  assign rd_idx = rd_ptr_reg[DEPTH_W-1:0];
  assign full   = (level == PTR_W'(DEPTH));
  assign empty  = (level == '0);

  // Acceptance uses the status seen before the edge, so read and write are independent.
  assign wr_acc = bus.wr_en && !full;
  assign rd_acc = bus.rd_en && !empty;

  assign bus.level        = level;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (level >= PTR_W'(AF_LVL));
  assign bus.almost_empty = (level <= PTR_W'(AE_LVL));
  assign bus.ovf_err      = ovf_err_reg;
  assign bus.udf_err      = udf_err_reg;

  // Pointers advance only on accepted requests and wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_acc) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_acc) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Storage is not reset so it can map onto block or distributed RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_idx] <= bus.wr_dat;
  end

  // A rejection in the same cycle as err_clr wins, so no event is lost.
  always_comb begin
    ovf_err_next = ovf_err_reg;
    udf_err_next = udf_err_reg;
    if (bus.err_clr) begin
      ovf_err_next = 1'b0;
      udf_err_next = 1'b0;
    end
    if (bus.wr_en && full)  ovf_err_next = 1'b1;
    if (bus.rd_en && empty) udf_err_next = 1'b1;
  end

  // Sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_err_reg <= 1'b0;
      udf_err_reg <= 1'b0;
    end else begin
      ovf_err_reg <= ovf_err_next;
      udf_err_reg <= udf_err_next;
    end
  end

`ifdef SYNC_FIFO_LVL_FWFT_EN
  // Head entry is presented directly; rd_en only acknowledges the pop.
  assign bus.rd_dat     = mem[rd_idx];
  assign bus.rd_dat_vld = !empty;
`else
  logic [DATA_W-1:0] rd_dat_reg;
  logic              rd_dat_vld_reg;

  // Registered read port: data captured on each accepted read, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_dat_reg     <= '0;
      rd_dat_vld_reg <= 1'b0;
    end else begin
      rd_dat_vld_reg <= rd_acc;
      if (rd_acc) rd_dat_reg <= mem[rd_idx];
    end
  end

  assign bus.rd_dat     = rd_dat_reg;
  assign bus.rd_dat_vld = rd_dat_vld_reg;
`endif

endmodule
